// File: rtl/vlc_packer_pkg.sv
// Shared state type and sizing helpers for the VLC bit packer and its aligner.
package vlc_packer_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Accumulator must hold one full output word plus the widest codeword.
  function automatic int acc_width(input int max_code_bits, input int out_bytes);
    return 8 * out_bytes + max_code_bits;
  endfunction

  function automatic int bytes_for_bits(input int fill);
    return (fill + 7) / 8;
  endfunction

endpackage

// File: rtl/vlc_bit_packer_if.sv
// Codeword input and packed-word output channels of the VLC bit packer.
// master = producer/consumer environment, slave = the packer itself.
interface vlc_bit_packer_if #(
  parameter int MAX_CODE_BITS = 32,
  parameter int OUT_BYTES     = 8
);
  localparam int OUT_W = 8 * OUT_BYTES;
  localparam int LEN_W = $clog2(MAX_CODE_BITS + 1);
  localparam int BC_W  = $clog2(OUT_BYTES + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [MAX_CODE_BITS-1:0] in_code;
  logic [LEN_W-1:0]         in_len;
  logic                     flush;

  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [BC_W-1:0]          out_byte_count;
  logic                     out_last;
  logic                     flush_done;

  modport master (
    output in_valid, in_code, in_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_byte_count, out_last, flush_done
  );

  modport slave (
    input  in_valid, in_code, in_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_byte_count, out_last, flush_done
  );

endinterface

// File: rtl/vlc_packer_align.sv
// Masks a codeword to its clamped length and left-aligns it below the current fill.
// Latency: combinational. Backpressure: none (pure function of inputs).
module vlc_packer_align
  import vlc_packer_pkg::*;
#(
  parameter int MAX_CODE_BITS = 32,
  parameter int ACC_W         = 96,
  parameter int FILL_W        = 7,
  parameter int LEN_W         = 6
) (
  input  logic [MAX_CODE_BITS-1:0] code,
  input  logic [LEN_W-1:0]         len,
  input  logic [FILL_W-1:0]        fill,
  output logic [ACC_W-1:0]         aligned,
  output logic [LEN_W-1:0]         len_clamped
);

  localparam int SH_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] mask;
  logic [ACC_W-1:0] code_ext;
  logic [SH_W-1:0]  shamt;
  int               shift_i;

  always_comb begin
    len_clamped = len;
    if (len > LEN_W'(MAX_CODE_BITS)) begin
      len_clamped = LEN_W'(MAX_CODE_BITS);
    end

    mask     = ~({ACC_W{1'b1}} << len_clamped);
    code_ext = {{(ACC_W - MAX_CODE_BITS){1'b0}}, code} & mask;

    // Code occupies [ACC_W-1-fill -: len]; its LSB lands at ACC_W-fill-len.
    shift_i = ACC_W - int'(fill) - int'(len_clamped);
    shamt   = '0;
    aligned = '0;
    if (shift_i >= 0) begin
      shamt   = SH_W'(shift_i);
      aligned = code_ext << shamt;
    end
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codewords MSB-first into OUT_W-bit words; flush pads tail to a byte.
// Latency: word valid the cycle after the completing codeword. Optional VLC_BIT_PACKER_BIT_COUNT_EN adds total_bits.
// Backpressure: input stalls while a full word is held; output word is stable until out_ready.
module vlc_bit_packer
  import vlc_packer_pkg::*;
#(
  parameter int MAX_CODE_BITS = 32,
  parameter int OUT_BYTES     = 8
) (
  input  logic CLOCK,
  input  logic RESET,
`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
  output logic [31:0] total_bits,
`endif
  vlc_bit_packer_if.slave bus
);

  localparam int OUT_W  = 8 * OUT_BYTES;
  localparam int ACC_W  = acc_width(MAX_CODE_BITS, OUT_BYTES);
  localparam int FILL_W = $clog2(ACC_W);
  localparam int LEN_W  = $clog2(MAX_CODE_BITS + 1);
  localparam int BC_W   = $clog2(OUT_BYTES + 1);

  pack_state_t       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;

  logic [ACC_W-1:0]  aligned;
  logic [LEN_W-1:0]  len_c;
  logic              in_ready_c;
  logic              full;
  logic              tail;
  logic              out_valid_c;
  logic              accept;
  logic              take_flush;
  logic              emit;
  logic [BC_W-1:0]   tail_bytes;

  vlc_packer_align #(
    .MAX_CODE_BITS (MAX_CODE_BITS),
    .ACC_W         (ACC_W),
    .FILL_W        (FILL_W),
    .LEN_W         (LEN_W)
  ) u_align (
    .code        (bus.in_code),
    .len         (bus.in_len),
    .fill        (fill_q),
    .aligned     (aligned),
    .len_clamped (len_c)
  );

  // Accept only while less than a full word is buffered, so accept and emit never overlap.
  always_comb begin
    full        = (fill_q >= FILL_W'(OUT_W));
    in_ready_c  = (state_q == RUN) && !full;
    tail        = (state_q == FLUSH) && !full && (fill_q != '0);
    out_valid_c = full || tail;
    accept      = bus.in_valid && in_ready_c;
    take_flush  = bus.flush && in_ready_c;
    emit        = out_valid_c && bus.out_ready;
    tail_bytes  = BC_W'(bytes_for_bits(int'(fill_q)));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          acc_d  = acc_q | aligned;
          fill_d = fill_q + FILL_W'(len_c);
        end else if (emit) begin
          acc_d  = acc_q << OUT_W;
          fill_d = fill_q - FILL_W'(OUT_W);
        end
        if (take_flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (full) begin
          if (emit) begin
            acc_d  = acc_q << OUT_W;
            fill_d = fill_q - FILL_W'(OUT_W);
          end
        end else if (fill_q == '0) begin
          done_d  = 1'b1;
          state_d = RUN;
        end else if (emit) begin
          acc_d   = '0;
          fill_d  = '0;
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  // Bits below fill are always zero, so the tail word is already zero-padded.
  always_comb begin
    bus.in_ready       = !RESET && in_ready_c;
    bus.out_valid      = !RESET && out_valid_c;
    bus.out_data       = RESET ? '0 : acc_q[ACC_W-1 -: OUT_W];
    bus.out_byte_count = '0;
    if (!RESET) begin
      bus.out_byte_count = tail ? tail_bytes : BC_W'(OUT_BYTES);
    end
    bus.out_last       = !RESET && tail;
    bus.flush_done     = !RESET && done_q;
  end

`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
  logic [31:0] total_q;

  // Value is visible during the flush_done cycle and restarts right after it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      total_q <= '0;
    end else if (done_q) begin
      total_q <= accept ? 32'(len_c) : '0;
    end else if (accept) begin
      total_q <= total_q + 32'(len_c);
    end
  end

  assign total_bits = total_q;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed scoreboard bench for vlc_bit_packer at default parameters.
module tb_vlc_bit_packer;

  logic clk;
  logic rst;

  vlc_bit_packer_if #(.MAX_CODE_BITS(32), .OUT_BYTES(8)) bus ();

`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
  logic [31:0] total_bits;
  logic [31:0] total_at_done;
`endif

  vlc_bit_packer #(.MAX_CODE_BITS(32), .OUT_BYTES(8)) dut (
    .CLOCK      (clk),
    .RESET      (rst),
`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
    .total_bits (total_bits),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bc;
    logic        last;
  } exp_t;

  exp_t expq[$];
  bit   bitq[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  int   n_words  = 0;
  bit   last_rdy = 0;
  bit   prev_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample/score at negedge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_rdy = bus.in_ready;
    if (bus.flush_done === 1'b1) begin
      check("flush_done_width", 64'(prev_done), 64'd0);
      n_done++;
`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
      total_at_done = total_bits;
`endif
    end
    prev_done = (bus.flush_done === 1'b1);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_words++;
      if (expq.size() == 0) begin
        check("unexpected_word", 64'(bus.out_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        check("word_data", bus.out_data, e.data);
        check("word_bytes", 64'(bus.out_byte_count), 64'(e.bc));
        check("word_last", 64'(bus.out_last), 64'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_words();
    exp_t e;
    while (bitq.size() >= 64) begin
      e.data = '0;
      for (int i = 63; i >= 0; i--) e.data[i] = bitq.pop_front();
      e.bc   = 4'd8;
      e.last = 1'b0;
      expq.push_back(e);
    end
  endtask

  task automatic model_flush();
    exp_t e;
    int   n;
    model_words();
    n = bitq.size();
    if (n > 0) begin
      e.data = '0;
      for (int i = 63; i >= 64 - n; i--) e.data[i] = bitq.pop_front();
      e.bc   = 4'((n + 7) / 8);
      e.last = 1'b1;
      expq.push_back(e);
    end
    exp_done++;
  endtask

  task automatic send(input logic [31:0] code, input logic [5:0] len, input logic v, input logic f);
    int l;
    bus.in_valid = v;
    bus.in_code  = code;
    bus.in_len   = len;
    bus.flush    = f;
    last_rdy     = 0;
    for (int t = 0; t < 200 && !last_rdy; t++) step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_code  = '0;
    bus.in_len   = '0;
    if (!last_rdy) begin
      check("send_timeout", 64'(last_rdy), 64'd1);
    end else begin
      if (v) begin
        l = (len > 6'd32) ? 32 : int'(len);
        for (int i = l - 1; i >= 0; i--) bitq.push_back(code[i]);
        model_words();
      end
      if (f) model_flush();
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200 && n_done < exp_done; t++) step();
    for (int t = 0; t < 4; t++) step();
    check("flush_done_count", 64'(n_done), 64'(exp_done));
    check("words_pending", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int words_before;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_len    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_byte_count", 64'(bus.out_byte_count), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_flush_done", 64'(bus.flush_done), 64'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Two short codes then a flush: single padded byte 0xA3.
    send(32'h5, 6'd3, 1'b1, 1'b0);
    send(32'h3, 6'd5, 1'b1, 1'b0);
    send(32'h0, 6'd0, 1'b0, 1'b1);
    wait_done();

    // Sixteen nibbles fill exactly one word, valid right after the 16th accept.
    for (int i = 1; i <= 16; i++) send(32'(i % 16), 6'd4, 1'b1, 1'b0);
    check("word_valid_latency", 64'(bus.out_valid), 64'd1);
    check("word_const", bus.out_data, 64'h123456789ABCDEF0);
    check("word_in_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    check("words_pending_t2", 64'(expq.size()), 64'd0);

    // Same word under five cycles of backpressure.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(32'(i % 16), 6'd4, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_data", bus.out_data, 64'h123456789ABCDEF0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    words_before  = n_words;
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    check("bp_taken_once", 64'(n_words - words_before), 64'd1);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);

    // Flush with nothing buffered, then code and flush in the same transfer.
    words_before = n_words;
    send(32'h0, 6'd0, 1'b0, 1'b1);
    wait_done();
    check("empty_flush_no_word", 64'(n_words - words_before), 64'd0);
    send(32'h7F, 6'd7, 1'b1, 1'b1);
    wait_done();

    // Masking of bits above in_len, including a zero-length code.
    send(32'hFFFFFFFF, 6'd1, 1'b1, 1'b0);
    send(32'h0, 6'd7, 1'b1, 1'b0);
    send(32'hDEADBEEF, 6'd0, 1'b1, 1'b0);
    send(32'h0, 6'd0, 1'b0, 1'b1);
    wait_done();
`ifdef VLC_BIT_PACKER_BIT_COUNT_EN
    check("total_bits", 64'(total_at_done), 64'd8);
`endif

    // Over-long length clamps to 32 bits.
    send(32'hCAFEBABE, 6'd40, 1'b1, 1'b0);
    send(32'h12345678, 6'd32, 1'b1, 1'b0);
    step();
    step();
    check("clamp_pending", 64'(expq.size()), 64'd0);

    // Reset during a flush drain discards everything.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(32'(8'h11 * k), 6'd8, 1'b1, 1'b0);
    send(32'h0, 6'd0, 1'b0, 1'b1);
    step();
    check("drain_tail_valid", 64'(bus.out_valid), 64'd1);
    check("drain_tail_last", 64'(bus.out_last), 64'd1);
    rst = 1'b1;
    step();
    bitq.delete();
    expq.delete();
    exp_done--;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    check("mid_rst_byte_count", 64'(bus.out_byte_count), 64'd0);
    check("mid_rst_out_last", 64'(bus.out_last), 64'd0);
    check("mid_rst_flush_done", 64'(bus.flush_done), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    send(32'h5A, 6'd8, 1'b1, 1'b1);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
